cpu86_bpu_ras: RTL and testbench

CPU86_BPU_RAS -- requirements
Module: cpu86_bpu_ras

---
 rtl/cpu86_bpu_ras_if.sv | 34 +++
 rtl/cpu86_bpu_ras.sv | 86 ++++++++
 tb/tb_cpu86_bpu_ras.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu86_bpu_ras_if.sv
// Bundle of the return-address-stack signals, shared between the predictor
// front end (master) and the stack itself (slave).
interface cpu86_bpu_ras_if #(
    parameter int DEPTH = 16,
    parameter int DW    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: push_vld writes unconditionally (the stack never stalls a call);
    // a pop happens only on a cycle where pop_vld && pop_ack are both high; pop_ack
    // while pop_vld is low is an underflow and changes nothing.
    logic          push_vld;
    logic [DW-1:0] push_data;
    logic          pop_vld;
    logic          pop_ack;
    logic [DW-1:0] pop_data;
    logic          snap_vld;
    logic          restore_vld;
    logic          flush;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic          underflow;

    modport master (
        output push_vld, push_data, pop_ack, snap_vld, restore_vld, flush,
        input  pop_vld, pop_data, count, full, overflow, underflow
    );

    modport slave (
        input  push_vld, push_data, pop_ack, snap_vld, restore_vld, flush,
        output pop_vld, pop_data, count, full, overflow, underflow
    );
endinterface

// File: rtl/cpu86_bpu_ras.sv
// Circular return-address stack with a single {tp, count} checkpoint for
// mispredict recovery; oldest entry is silently overwritten on overflow.
module cpu86_bpu_ras #(
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input logic            clk,
    input logic            reset,
    cpu86_bpu_ras_if.slave ras
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] tp, tp_nxt, ck_tp, waddr;
    logic [CW-1:0] cnt, cnt_nxt, ck_cnt;
    logic          we, eff_pop, is_full, ov_nxt, un_nxt, ov_q, un_q;

    assign is_full = (cnt == CW'(DEPTH));
    assign eff_pop = ras.pop_ack && (cnt != '0);

    always_comb begin
        tp_nxt  = tp;
        cnt_nxt = cnt;
        we      = 1'b0;
        waddr   = tp;
        ov_nxt  = 1'b0;
        un_nxt  = 1'b0;
        if (ras.flush) begin
            tp_nxt  = '0;
            cnt_nxt = '0;
        end else if (ras.restore_vld) begin
            tp_nxt  = ck_tp;
            cnt_nxt = ck_cnt;
        end else if (ras.push_vld && eff_pop) begin
            // ret+call in one cycle replaces the top in place
            we    = 1'b1;
            waddr = tp;
        end else if (ras.push_vld) begin
            tp_nxt  = tp + AW'(1);
            we      = 1'b1;
            waddr   = tp + AW'(1);
            cnt_nxt = is_full ? cnt : cnt + CW'(1);
            ov_nxt  = is_full;
            un_nxt  = ras.pop_ack;
        end else if (eff_pop) begin
            tp_nxt  = tp - AW'(1);
            cnt_nxt = cnt - CW'(1);
        end else if (ras.pop_ack) begin
            un_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tp     <= '0;
            cnt    <= '0;
            ck_tp  <= '0;
            ck_cnt <= '0;
            ov_q   <= 1'b0;
            un_q   <= 1'b0;
        end else begin
            tp   <= tp_nxt;
            cnt  <= cnt_nxt;
            ov_q <= ov_nxt;
            un_q <= un_nxt;
            // checkpoint takes pre-update state, after restore has read the old one
            if (ras.snap_vld) begin
                ck_tp  <= tp;
                ck_cnt <= cnt;
            end
        end
    end

    // Data array is never reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (we && !reset) mem[waddr] <= ras.push_data;
    end

    assign ras.pop_data  = mem[tp];
    assign ras.pop_vld   = (cnt != '0);
    assign ras.full      = is_full;
    assign ras.count     = cnt;
    assign ras.overflow  = ov_q;
    assign ras.underflow = un_q;
endmodule

// File: tb/tb_cpu86_bpu_ras.sv
// Directed scenarios plus random traffic for cpu86_bpu_ras, checked against
// a circular-stack reference model kept in the bench.
module tb_cpu86_bpu_ras;
    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu86_bpu_ras_if #(.DEPTH(DEPTH), .DW(DW)) ras ();

    cpu86_bpu_ras #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .ras   (ras)
    );

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int m_tp, m_cnt, m_ck_tp, m_ck_cnt;
    bit m_ov, m_un;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tp = 0; m_cnt = 0; m_ck_tp = 0; m_ck_cnt = 0; m_ov = 0; m_un = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     32'(ras.count),     32'(m_cnt));
        check({tag, ".pop_vld"},   32'(ras.pop_vld),   32'(m_cnt != 0));
        check({tag, ".full"},      32'(ras.full),      32'(m_cnt == DEPTH));
        check({tag, ".overflow"},  32'(ras.overflow),  32'(m_ov));
        check({tag, ".underflow"}, 32'(ras.underflow), 32'(m_un));
        if (m_cnt != 0) check({tag, ".pop_data"}, 32'(ras.pop_data), 32'(m_mem[m_tp]));
    endtask

    task automatic step(input string tag, input bit push, input logic [DW-1:0] d,
                        input bit pop, input bit snap, input bit rest, input bit fl);
        int n_tp, n_cnt;
        bit eff;
        ras.push_vld    = push;
        ras.push_data   = d;
        ras.pop_ack     = pop;
        ras.snap_vld    = snap;
        ras.restore_vld = rest;
        ras.flush       = fl;
        n_tp = m_tp; n_cnt = m_cnt; m_ov = 0; m_un = 0;
        eff = pop && (m_cnt > 0);
        if (fl) begin
            n_tp = 0; n_cnt = 0;
        end else if (rest) begin
            n_tp = m_ck_tp; n_cnt = m_ck_cnt;
        end else if (push && eff) begin
            m_mem[m_tp] = d;
        end else if (push) begin
            m_ov  = (m_cnt == DEPTH);
            m_un  = pop;
            n_tp  = (m_tp + 1) % DEPTH;
            m_mem[n_tp] = d;
            n_cnt = (m_cnt == DEPTH) ? DEPTH : m_cnt + 1;
        end else if (eff) begin
            n_tp  = (m_tp + DEPTH - 1) % DEPTH;
            n_cnt = m_cnt - 1;
        end else if (pop) begin
            m_un = 1;
        end
        if (snap) begin
            m_ck_tp = m_tp; m_ck_cnt = m_cnt;
        end
        @(posedge clk);
        #1;
        m_tp = n_tp; m_cnt = n_cnt;
        check_all(tag);
    endtask

    task automatic push1(input logic [DW-1:0] d);
        step("push", 1, d, 0, 0, 0, 0);
    endtask

    task automatic pop1();
        step("pop", 0, '0, 1, 0, 0, 0);
    endtask

    initial begin
        ras.push_vld = 0; ras.push_data = '0; ras.pop_ack = 0;
        ras.snap_vld = 0; ras.restore_vld = 0; ras.flush = 0;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("reset_async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");

        // LIFO order
        push1(16'h11); push1(16'h22); push1(16'h33);
        check("lifo.top", 32'(ras.pop_data), 32'h33);
        pop1(); check("lifo.pop1", 32'(ras.pop_data), 32'h22);
        pop1(); check("lifo.pop2", 32'(ras.pop_data), 32'h11);
        pop1(); check("lifo.empty", 32'(ras.pop_vld), 32'h0);

        // overflow overwrites the oldest
        for (int i = 0; i < 5; i++) push1(DW'(16'hA1 + i));
        check("ovf.pulse", 32'(ras.overflow), 32'h1);
        check("ovf.full", 32'(ras.full), 32'h1);
        check("ovf.top", 32'(ras.pop_data), 32'hA5);
        for (int i = 0; i < 4; i++) pop1();
        check("ovf.drained", 32'(ras.count), 32'h0);

        // push with pop replaces the top
        push1(16'h11); push1(16'h22);
        step("swap", 1, 16'h77, 1, 0, 0, 0);
        check("swap.top", 32'(ras.pop_data), 32'h77);
        check("swap.count", 32'(ras.count), 32'h2);
        pop1();
        check("swap.next", 32'(ras.pop_data), 32'h11);
        step("flush", 0, '0, 0, 0, 0, 1);

        // checkpoint / restore / flush priority
        push1(16'h11);
        step("snap", 0, '0, 0, 1, 0, 0);
        push1(16'h22); push1(16'h33);
        step("restore", 0, '0, 0, 0, 1, 0);
        check("restore.count", 32'(ras.count), 32'h1);
        check("restore.top", 32'(ras.pop_data), 32'h11);
        step("prio", 1, 16'h55, 0, 0, 1, 1);
        check("prio.count", 32'(ras.count), 32'h0);

        // underflow and push-while-empty-with-pop
        pop1();
        check("unf.pulse", 32'(ras.underflow), 32'h1);
        step("idle", 0, '0, 0, 0, 0, 0);
        step("push_unf", 1, 16'h44, 1, 0, 0, 0);
        check("push_unf.count", 32'(ras.count), 32'h1);

        // asynchronous reset between edges
        push1(16'h45); push1(16'h46);
        check("pre_rst.count", 32'(ras.count), 32'h3);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_rst.count", 32'(ras.count), 32'h0);
        check("async_rst.pop_vld", 32'(ras.pop_vld), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("post_rst");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step("rand", $urandom_range(0, 99) < 50, DW'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3);
        end
        step("tail", 0, '0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
